// File: rtl/i2c_mem_master_pkg.sv
// Shared definitions for the I2C memory master and slave: bus widths, the
// slave address, the master FSM state type and an address-widening helper.
package i2c_mem_master_pkg;

   localparam int unsigned DATAWIDTH     = 8;
   localparam int unsigned ADDRWIDTH     = 8;
   localparam int unsigned SLV_ADDR_SIZE = 7;
   localparam logic [SLV_ADDR_SIZE-1:0] SLV_ADDR_PARAM = 7'h50;
   localparam int unsigned I2C_BYTE      = 8;

   typedef enum logic [2:0] {
      IDLE,
      START_C,
      SHIFT,
      ACK,
      STOP_A,
      STOP_B,
      DONE,
      GAP
   } i2c_mst_state_t;

   function automatic logic [I2C_BYTE-1:0] zext_addr(input logic [ADDRWIDTH-1:0] a);
      logic [I2C_BYTE-1:0] v;
      v = '0;
      v[ADDRWIDTH-1:0] = a;
      return v;
   endfunction

endpackage

// File: rtl/i2c_mem_master_scl_gen.sv
// SCL phase timer: divides clk into quarter-bit phases q0..q3 and produces
// the SCL level, either toggling with the bit phase or held at a fixed level.
module i2c_scl_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   input  logic       i_half,
   input  logic       i_toggle,
   input  logic       i_level,
   output logic [1:0] o_q,
   output logic       o_tick,
   output logic       o_qstart,
   output logic       o_scl
);

   logic [7:0] r_cnt;
   logic [1:0] r_q;

   assign o_tick   = (r_cnt == 8'(CLK_DIV - 1));
   assign o_qstart = (r_cnt == '0);
   assign o_q      = r_q;
   assign o_scl    = i_toggle ? r_q[1] : i_level;

   // Half-length phases (start/stop) span q0..q1 only, so q wraps early.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_q   <= '0;
      end else if (!i_en) begin
         r_cnt <= '0;
         r_q   <= '0;
      end else if (o_tick) begin
         r_cnt <= '0;
         r_q   <= (i_half && (r_q == 2'd1)) ? 2'd0 : r_q + 2'd1;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/i2c_mem_master.sv
// I2C initiator issuing write and read-address frames to the memory slave.
// Optional NACK retry is enabled by defining I2C_NACK_RETRY_EN.
module i2c_mem_master
   import i2c_mem_master_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 rw,
   input  logic [ADDRWIDTH-1:0] mem_addr,
   input  logic [DATAWIDTH-1:0] wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 ack_err,
   output logic                 scl,
   inout  logic                 sda
);

`ifdef I2C_NACK_RETRY_EN
   localparam logic RETRY_EN = 1'b1;
`else
   localparam logic RETRY_EN = 1'b0;
`endif

   i2c_mst_state_t r_state;
   i2c_mst_state_t w_next;

   logic                 r_rw;
   logic [ADDRWIDTH-1:0] r_addr;
   logic [DATAWIDTH-1:0] r_wdata;
   logic [I2C_BYTE-1:0]  r_tx;
   logic [2:0]           r_bitcnt;
   logic [1:0]           r_byte;
   logic                 r_nack;
   logic                 r_ack_err;
   logic [7:0]           r_retry;

   logic [1:0] w_q;
   logic       w_tick;
   logic       w_qstart;
   logic       w_busy;
   logic       w_half;
   logic       w_scl_toggle;
   logic       w_scl_level;
   logic       w_sda_low;
   logic       w_bit_end;
   logic       w_half_end;
   logic       w_ack_smp;
   logic       w_retry;

   i2c_scl_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_scl_gen (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_busy),
      .i_half   (w_half),
      .i_toggle (w_scl_toggle),
      .i_level  (w_scl_level),
      .o_q      (w_q),
      .o_tick   (w_tick),
      .o_qstart (w_qstart),
      .o_scl    (scl)
   );

   assign w_bit_end  = w_tick && (w_q == 2'd3);
   assign w_half_end = w_tick && (w_q == 2'd1);
   assign w_ack_smp  = (r_state == ACK) && (w_q == 2'd2) && w_qstart;
   assign w_retry    = RETRY_EN && r_nack && (r_retry < 8'(MAX_RETRY));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start)      w_next = START_C;
         START_C: if (w_half_end) w_next = SHIFT;
         SHIFT:   if (w_bit_end && (r_bitcnt == 3'd0)) w_next = ACK;
         ACK: begin
            if (w_bit_end) begin
               if (r_nack)
                  w_next = STOP_A;
               else if ((r_byte == 2'd0) || ((r_byte == 2'd1) && !r_rw))
                  w_next = SHIFT;
               else
                  w_next = STOP_A;
            end
         end
         STOP_A:  if (w_half_end) w_next = STOP_B;
         STOP_B:  if (w_half_end) w_next = w_retry ? GAP : DONE;
         GAP:     if (w_bit_end)  w_next = START_C;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_sda_low    = 1'b0;
      w_scl_toggle = 1'b0;
      w_scl_level  = 1'b1;
      w_half       = 1'b0;
      w_busy       = (r_state != IDLE);
      case (r_state)
         START_C: begin
            w_sda_low = 1'b1;
            w_half    = 1'b1;
         end
         SHIFT: begin
            w_sda_low    = ~r_tx[I2C_BYTE-1];
            w_scl_toggle = 1'b1;
         end
         ACK:     w_scl_toggle = 1'b1;
         STOP_A: begin
            w_sda_low   = 1'b1;
            w_scl_level = 1'b0;
            w_half      = 1'b1;
         end
         STOP_B: begin
            w_sda_low = 1'b1;
            w_half    = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy    = w_busy;
   assign done    = (r_state == DONE);
   assign ack_err = r_ack_err;
   assign sda     = w_sda_low ? 1'b0 : 1'bz;

   // The bit counter wraps 0 -> 7 on its own, so each new byte starts at bit 7.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rw      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_tx      <= '0;
         r_bitcnt  <= '0;
         r_byte    <= '0;
         r_nack    <= 1'b0;
         r_ack_err <= 1'b0;
         r_retry   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_rw      <= rw;
                  r_addr    <= mem_addr;
                  r_wdata   <= wdata;
                  r_tx      <= {SLV_ADDR_PARAM, rw};
                  r_bitcnt  <= 3'd7;
                  r_byte    <= '0;
                  r_nack    <= 1'b0;
                  r_ack_err <= 1'b0;
                  r_retry   <= '0;
               end
            end
            SHIFT: begin
               if (w_bit_end) begin
                  r_tx     <= {r_tx[I2C_BYTE-2:0], 1'b0};
                  r_bitcnt <= r_bitcnt - 3'd1;
               end
            end
            ACK: begin
               if (w_ack_smp && sda)
                  r_nack <= 1'b1;
               if (w_bit_end && !r_nack) begin
                  r_byte <= r_byte + 2'd1;
                  r_tx   <= (r_byte == 2'd0) ? zext_addr(r_addr) : r_wdata;
               end
            end
            STOP_B: begin
               if (w_half_end) begin
                  if (w_retry) begin
                     r_retry <= r_retry + 8'd1;
                     r_nack  <= 1'b0;
                  end else begin
                     r_ack_err <= r_nack;
                  end
               end
            end
            GAP: begin
               if (w_bit_end) begin
                  r_tx     <= {SLV_ADDR_PARAM, r_rw};
                  r_bitcnt <= 3'd7;
                  r_byte   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_mem_master.sv
// Directed bench for i2c_mem_master with a behavioural I2C memory responder
// that samples the bus on the falling clk edge and acknowledges each byte.
module tb_i2c_mem_master;
   import i2c_mem_master_pkg::*;

   localparam int CD = 4;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 start = 1'b0;
   logic                 rw = 1'b0;
   logic [ADDRWIDTH-1:0] mem_addr = '0;
   logic [DATAWIDTH-1:0] wdata = '0;
   logic                 busy, done, ack_err, scl;
   wire                  sda;
   logic                 tb_drv = 1'b0;

   assign sda = tb_drv ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_mem_master #(
      .CLK_DIV   (CD),
      .MAX_RETRY (3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .rw       (rw),
      .mem_addr (mem_addr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .scl      (scl),
      .sda      (sda)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic       p_scl = 1'b1, p_sda = 1'b1;
   int         bitn = 0, byte_i = 0, last_nbytes = 0;
   int         nack_req = 0, nack_used = 0;
   int         n_start = 0, n_stop = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
   logic [7:0] shreg = '0;
   logic [7:0] mb [0:3];
   logic [7:0] wr_addr = '0, wr_data = '0, rd_addr = '0;

   // Responder: decodes START/STOP/bits from sampled levels, drives ACK low.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (!reset) begin
         tb_drv = 1'b0;
         bitn   = 0;
         byte_i = 0;
      end else if (p_scl && scl && p_sda && !sda) begin
         n_start++;
         bitn   = 0;
         byte_i = 0;
         tb_drv = 1'b0;
      end else if (p_scl && scl && !p_sda && sda) begin
         n_stop++;
         last_nbytes = byte_i;
         if (byte_i == 3 && mb[0] == {SLV_ADDR_PARAM, 1'b0}) begin
            wr_cnt++;
            wr_addr = mb[1];
            wr_data = mb[2];
         end else if (byte_i == 2 && mb[0] == {SLV_ADDR_PARAM, 1'b1}) begin
            rd_cnt++;
            rd_addr = mb[1];
         end
      end else if (!p_scl && scl) begin
         if (bitn < 8) shreg = {shreg[6:0], sda};
         bitn++;
      end else if (p_scl && !scl) begin
         if (bitn == 8) begin
            if (byte_i < 4) mb[byte_i] = shreg;
            if (byte_i == 0 && nack_used < nack_req) nack_used++;
            else tb_drv = 1'b1;
         end else if (bitn == 9) begin
            tb_drv = 1'b0;
            bitn   = 0;
            byte_i++;
         end
      end
      p_scl = scl;
      p_sda = sda;
   end

   task automatic run_frame(input logic r, input logic [7:0] a, input logic [7:0] d,
                            output int k, output logic busy1);
      @(posedge clk); #1;
      rw = r; mem_addr = a; wdata = d; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy1 = busy;
      k = -1;
      for (int i = 1; i <= 4000; i++) begin
         @(posedge clk); #1;
         if (done) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #3;
      checks++; if (scl !== 1'b1) begin failures++; $display("FAIL reset_scl: got %b expected 1", scl); end
      checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b expected 1", sda); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_write;
      int k, w0;
      logic b1;
      w0 = wr_cnt;
      run_frame(1'b0, 8'h3C, 8'hA5, k, b1);
      checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL wr_busy_after_accept: got %b expected 1", b1); end
      checks++; if (k + 2 != 2*CD + 27*4*CD + 4*CD + 2) begin failures++; $display("FAIL wr_latency: got %0d expected %0d", k + 2, 2*CD + 27*4*CD + 4*CD + 2); end
      checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL wr_ack_err: got %b expected 0", ack_err); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL wr_done_width: got %b expected 0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_end: got %b expected 0", busy); end
      repeat (4) @(posedge clk);
      checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL wr_en_pulses: got %0d expected 1", wr_cnt - w0); end
      checks++; if (wr_addr !== 8'h3C) begin failures++; $display("FAIL wr_addr: got %h expected 3c", wr_addr); end
      checks++; if (wr_data !== 8'hA5) begin failures++; $display("FAIL wr_data: got %h expected a5", wr_data); end
   endtask

   task automatic test_read;
      int k, r0, w0;
      logic b1;
      r0 = rd_cnt; w0 = wr_cnt;
      run_frame(1'b1, 8'h07, 8'hFF, k, b1);
      checks++; if (k + 2 != 2*CD + 18*4*CD + 4*CD + 2) begin failures++; $display("FAIL rd_latency: got %0d expected %0d", k + 2, 2*CD + 18*4*CD + 4*CD + 2); end
      checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL rd_ack_err: got %b expected 0", ack_err); end
      repeat (4) @(posedge clk);
      checks++; if (rd_cnt - r0 != 1) begin failures++; $display("FAIL rd_en_pulses: got %0d expected 1", rd_cnt - r0); end
      checks++; if (rd_addr !== 8'h07) begin failures++; $display("FAIL rd_addr: got %h expected 07", rd_addr); end
      checks++; if (last_nbytes != 2) begin failures++; $display("FAIL rd_nbytes: got %0d expected 2", last_nbytes); end
      checks++; if (wr_cnt != w0) begin failures++; $display("FAIL rd_no_write: got %0d expected %0d", wr_cnt, w0); end
   endtask

`ifndef I2C_NACK_RETRY_EN
   task automatic test_nack;
      int k, w0, s0;
      logic b1;
      w0 = wr_cnt; s0 = n_start;
      nack_req = nack_used + 1;
      run_frame(1'b0, 8'h3C, 8'hA5, k, b1);
      checks++; if (k + 2 != 2*CD + 9*4*CD + 4*CD + 2) begin failures++; $display("FAIL nack_latency: got %0d expected %0d", k + 2, 2*CD + 9*4*CD + 4*CD + 2); end
      checks++; if (ack_err !== 1'b1) begin failures++; $display("FAIL nack_ack_err: got %b expected 1", ack_err); end
      repeat (4) @(posedge clk);
      checks++; if (last_nbytes != 1) begin failures++; $display("FAIL nack_nbytes: got %0d expected 1", last_nbytes); end
      checks++; if (wr_cnt != w0) begin failures++; $display("FAIL nack_no_write: got %0d expected %0d", wr_cnt, w0); end
      checks++; if (n_start - s0 != 1) begin failures++; $display("FAIL nack_starts: got %0d expected 1", n_start - s0); end
   endtask
`else
   task automatic test_retry;
      int k, w0, s0;
      logic b1;
      w0 = wr_cnt; s0 = n_start;
      nack_req = nack_used + 2;
      run_frame(1'b0, 8'h3C, 8'hA5, k, b1);
      checks++; if (k != 2*(42*CD + 4*CD) + 114*CD) begin failures++; $display("FAIL retry_latency: got %0d expected %0d", k, 2*(42*CD + 4*CD) + 114*CD); end
      checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL retry_ack_err: got %b expected 0", ack_err); end
      repeat (4) @(posedge clk);
      checks++; if (n_start - s0 != 3) begin failures++; $display("FAIL retry_starts: got %0d expected 3", n_start - s0); end
      checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL retry_write: got %0d expected 1", wr_cnt - w0); end
   endtask
`endif

   task automatic test_reset_mid;
      int k, w0, s0;
      logic b1, found;
      @(posedge clk); #1;
      rw = 1'b0; mem_addr = 8'h66; wdata = 8'h99; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL accept_clears_ack_err: got %b expected 0", ack_err); end
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (byte_i == 1 && bitn == 4 && scl == 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      checks++; if (found !== 1'b1) begin failures++; $display("FAIL rst_mid_reach_bit3: got %b expected 1", found); end
      #2 reset = 1'b0;
      #1;
      checks++; if (scl !== 1'b1) begin failures++; $display("FAIL rst_mid_scl: got %b expected 1", scl); end
      checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rst_mid_sda: got %b expected 1", sda); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done: got %b expected 0", done); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      w0 = wr_cnt; s0 = n_start;
      run_frame(1'b0, 8'h5A, 8'hC3, k, b1);
      checks++; if (k + 2 != 2*CD + 27*4*CD + 4*CD + 2) begin failures++; $display("FAIL rst_clean_latency: got %0d expected %0d", k + 2, 2*CD + 27*4*CD + 4*CD + 2); end
      repeat (4) @(posedge clk);
      checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL rst_clean_write: got %0d expected 1", wr_cnt - w0); end
      checks++; if (wr_addr !== 8'h5A || wr_data !== 8'hC3) begin failures++; $display("FAIL rst_clean_bytes: got %h %h expected 5a c3", wr_addr, wr_data); end
      checks++; if (n_start - s0 != 1) begin failures++; $display("FAIL rst_clean_starts: got %0d expected 1", n_start - s0); end
   endtask

   task automatic test_back_to_back;
      int k, w0, r0, d0;
      w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
      @(posedge clk); #1;
      rw = 1'b0; mem_addr = 8'h12; wdata = 8'h34; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = -1;
      for (int i = 1; i <= 4000; i++) begin
         @(posedge clk); #1;
         start = (i == 20);
         if (i == 20) begin
            rw = 1'b1; mem_addr = 8'hEE; wdata = 8'h00;
         end
         if (done) begin
            k = i;
            break;
         end
      end
      checks++; if (k + 2 != 2*CD + 27*4*CD + 4*CD + 2) begin failures++; $display("FAIL busy_start_latency: got %0d expected %0d", k + 2, 2*CD + 27*4*CD + 4*CD + 2); end
      // start raised in the done cycle must not launch a frame
      rw = 1'b1; mem_addr = 8'h77; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_on_done_busy: got %b expected 0", busy); end
      repeat (60) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_on_done_idle: got %b expected 0", busy); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL busy_done_pulses: got %0d expected 1", done_cnt - d0); end
      checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL busy_write_count: got %0d expected 1", wr_cnt - w0); end
      checks++; if (wr_addr !== 8'h12 || wr_data !== 8'h34) begin failures++; $display("FAIL busy_write_bytes: got %h %h expected 12 34", wr_addr, wr_data); end
      checks++; if (rd_cnt != r0) begin failures++; $display("FAIL busy_no_read: got %0d expected %0d", rd_cnt, r0); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
`ifndef I2C_NACK_RETRY_EN
      test_nack();
`else
      test_retry();
`endif
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/i2c_mem_master.md
Name: i2c_mem_master

Overview:
- I2C initiator that issues memory write and read-address transactions to the on-chip I2C memory slave.
- Generates push-pull SCL and open-drain SDA.
- Serialises frames MSB-first:
  - Write: START, {SLV_ADDR_PARAM, 0}, ACK, mem_addr, ACK, wdata, ACK, STOP.
  - Read-address: START, {SLV_ADDR_PARAM, 1}, ACK, mem_addr, ACK, STOP.
- Sits between the host-side request logic and the sda/scl pins of the memory subsystem.

Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period. Bit period is 4*CLK_DIV clk cycles. Legal range 2..255.
- MAX_RETRY, 3: re-attempts after NACK. Used only with I2C_NACK_RETRY_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request strobe, sampled only in IDLE
- rw  in  1  0 = write frame, 1 = read-address frame
- mem_addr  in  ADDRWIDTH  target memory address, zero-extended to 8 bits on the wire
- wdata  in  DATAWIDTH  write data (DATAWIDTH = 8)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  set with done when any ACK slot sampled high; cleared on next accepted start
- scl  out  1  I2C clock, push-pull
- sda  inout  1  I2C data, open-drain: drives 0 or 'z, never 1

Behaviour:
- Reset (reset = 0, asynchronous):
  - state IDLE; scl = 1; sda released; busy = 0; done = 0; ack_err = 0.
  - Phase counter and bit counter cleared.
- Phase timer:
  - Counts 0..CLK_DIV-1 while busy.
  - Each wrap advances the quarter-phase q (0..3) of the current bit.
  - scl = 0 in q0/q1 and 1 in q2/q3 during data and ACK bits.
  - SDA changes only at q0 entry; ACK is sampled at the first clk of q2.
- Accept: in IDLE with start = 1:
  - Latch rw, mem_addr, wdata, and tx shift register = {SLV_ADDR_PARAM, rw}.
  - busy = 1 next cycle.
  - start is ignored while busy.
- States:
  - IDLE -> START_C on start.
  - START_C: scl = 1, sda pulled 0 for 2*CLK_DIV cycles -> SHIFT.
  - SHIFT: 8 bits, MSB first, bit counter 7..0. After bit 0 -> ACK.
  - ACK: sda released for one bit period, sda sampled in q2.
    - Sample 1 sets an internal nack flag.
    - After ACK: byte index 0 -> load mem_addr, SHIFT.
    - Byte index 1 and rw = 0 -> load wdata, SHIFT.
    - Byte index 1 and rw = 1 -> STOP_A.
    - Byte index 2 -> STOP_A.
  - NACK: abort to STOP_A immediately after that ACK slot; remaining bytes are not sent.
  - STOP_A: scl = 0, sda = 0 for 2*CLK_DIV cycles.
  - STOP_B: scl = 1, sda = 0 for 2*CLK_DIV cycles, then release sda -> DONE.
  - DONE: done = 1 for exactly one cycle; ack_err = nack flag; busy = 0 next cycle -> IDLE.
- Latency:
  - Write frame = 2*CLK_DIV (start) + 27*4*CLK_DIV (three 9-bit slots) + 4*CLK_DIV (stop) + 2 cycles, accept to done.
  - Read-address frame has 18 slots instead of 27.
- Start on the same cycle as done: ignored, because the block is not in IDLE.
- Reset mid-frame: lines return to idle levels asynchronously (scl = 1, sda released). No STOP is generated.

Optional Feature:
- Macro I2C_NACK_RETRY_EN.
- Defined:
  - On NACK, after STOP_B, return to START_C and resend the whole frame, up to MAX_RETRY times, with a 4*CLK_DIV idle gap at scl = 1, sda = 1.
  - ack_err is asserted only if the final attempt NACKs.
  - Retry counter is cleared on accept.
- Undefined:
  - No retry; first NACK ends the transaction with ack_err = 1.

Decomposition:
- Package definitions provides DATAWIDTH, ADDRWIDTH, SLV_ADDR_SIZE and SLV_ADDR_PARAM (shared with the slave).
- Add to the package: the state enum type i2c_mst_state_t and localparam I2C_BYTE = 8.
- One sub-module, i2c_scl_gen: phase timer plus quarter-phase output q and the scl level; enabled by busy.
- Shifter, FSM and sda driver stay in i2c_mem_master.

Test Plan:
- Write, slave present: CLK_DIV = 4, rw = 0, mem_addr = 8'h3C, wdata = 8'hA5 -> bus shows {SLV_ADDR_PARAM, 0}, 3C, A5, three ACKs sampled low; slave wr_en pulses; done after 2*4+108*4+4*4+2 cycles; ack_err = 0.
- Read-address: rw = 1, mem_addr = 8'h07 -> two bytes only, then STOP; slave rd_en pulses with addr = 8'h07; ack_err = 0.
- NACK on address byte: bench model holds SDA high in first ACK slot, no retry -> STOP immediately after slot 1; done with ack_err = 1; mem_addr is never driven.
- Reset mid-SHIFT: assert reset during bit 3 of byte 1 -> same-cycle scl = 1, sda = 'z, busy = 0; a new start after release produces a clean frame.
- Start while busy: pulse start at cycle 20 of an active write -> ignored; exactly one done pulse.
- With I2C_NACK_RETRY_EN, MAX_RETRY = 3, responder NACKs twice then ACKs -> three START conditions observed; done with ack_err = 0.
